// File: rtl/pool_out_buffer_if.sv
// Handshake bundle between the max-pooler, the pooled-output buffer and the consumer.
// The buffer uses the slave modport. The producer/consumer side uses the master modport.
interface pool_out_buffer_if #(
    parameter int DW = 16
);
    logic          pl_valid;
    logic [5:0]    pl_addr;
    logic [DW-1:0] pl_data;
    logic [2:0]    pl_his;
    logic          pl_done;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_his;
    logic [5:0]    out_idx;
    logic          out_last;

    modport master (
        output pl_valid, pl_addr, pl_data, pl_his, pl_done, out_ready,
        input  out_valid, out_data, out_his, out_idx, out_last
    );

    modport slave (
        input  pl_valid, pl_addr, pl_data, pl_his, pl_done, out_ready,
        output out_valid, out_data, out_his, out_idx, out_last
    );
endinterface

// File: rtl/pool_out_buffer.sv
// Captures the pooled stream into an N*N register buffer, then replays it in address order.
// Optional macro POOL_OUT_RELU_EN: negative pooled values are stored as zero.
module pool_out_buffer #(
    parameter int N  = 3,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pool_out_buffer_if.slave     bus,
    output logic                 busy,
    output logic                 buf_done,
    output logic                 err
);
    localparam int         DEPTH    = N * N;
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         WW       = DW + 3;
    localparam logic [6:0] DEPTH_C  = 7'(DEPTH);
    localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    function automatic logic [DW-1:0] store_value(input logic [DW-1:0] v);
`ifdef POOL_OUT_RELU_EN
        return v[DW-1] ? {DW{1'b0}} : v;
`else
        return v;
`endif
    endfunction

    state_t        state_q, state_d;
    logic [6:0]    count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [2:0]    out_his_q, out_his_d;
    logic [5:0]    out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;
    logic          buf_done_q, buf_done_d;
    logic          err_q, err_d;

    logic [WW-1:0] mem_q [0:DEPTH-1];
    logic          addr_ok_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [WW-1:0] wr_word_s;
    logic [AW-1:0] rd_addr_s;
    logic [WW-1:0] rd_word_s;
    logic [5:0]    nxt_idx_s;

    assign addr_ok_s = ({1'b0, bus.pl_addr} < DEPTH_C);
    assign wr_addr_s = bus.pl_addr[AW-1:0];
    assign wr_word_s = {store_value(bus.pl_data), bus.pl_his};
    assign nxt_idx_s = out_idx_q + 6'd1;
    assign rd_word_s = mem_q[rd_addr_s];

    // Next-state, capture write enable and output-register loading.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_his_d   = out_his_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        buf_done_d  = 1'b0;
        err_d       = err_q;
        wr_en_s     = 1'b0;
        rd_addr_s   = {AW{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (bus.pl_valid) begin
                    state_d = ST_CAPTURE;
                    if (addr_ok_s) begin
                        wr_en_s = 1'b1;
                        count_d = 7'd1;
                    end else begin
                        count_d = 7'd0;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (bus.pl_valid && addr_ok_s) begin
                    wr_en_s = 1'b1;
                    count_d = (count_q < DEPTH_C) ? (count_q + 7'd1) : count_q;
                end else if (bus.pl_valid) begin
                    err_d = 1'b1;
                end else begin
                    count_d = count_q;
                end
                // Either end-of-pass pulse or the active signal dropping closes the pass.
                if (bus.pl_done || !bus.pl_valid) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (bus.pl_valid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                // out_valid is low only on the first drain cycle: present entry 0.
                if (!out_valid_q) begin
                    rd_addr_s   = {AW{1'b0}};
                    out_valid_d = 1'b1;
                    out_data_d  = rd_word_s[WW-1:3];
                    out_his_d   = rd_word_s[2:0];
                    out_idx_d   = 6'd0;
                    out_last_d  = (LAST_IDX == 6'd0);
                    if (count_q < DEPTH_C) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_d;
                    end
                end else if (bus.out_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        buf_done_d  = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        rd_addr_s   = nxt_idx_s[AW-1:0];
                        out_data_d  = rd_word_s[WW-1:3];
                        out_his_d   = rd_word_s[2:0];
                        out_idx_d   = nxt_idx_s;
                        out_last_d  = (nxt_idx_s == LAST_IDX);
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= 7'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            out_his_q   <= 3'd0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            buf_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_his_q   <= out_his_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            buf_done_q  <= buf_done_d;
            err_q       <= err_d;
        end
    end

    // Buffer storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_word_s;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_his   = out_his_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign buf_done      = buf_done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_pool_out_buffer.sv
// Directed bench for pool_out_buffer (N=3, DW=16): capture passes, drain order, backpressure,
// error flag, reset mid-drain and optional ReLU storage.
module tb_pool_out_buffer;
    logic clk;
    logic rst_n;
    logic busy;
    logic buf_done;
    logic err;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0]  cap_addr [0:15];
    logic [15:0] cap_data [0:15];
    logic [2:0]  cap_his  [0:15];
    logic [15:0] exp_data [0:8];
    logic [2:0]  exp_his  [0:8];

    pool_out_buffer_if #(.DW(16)) bus ();

    pool_out_buffer #(.N(3), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .buf_done (buf_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_seq(input int mult);
        for (int i = 0; i < 9; i++) begin
            cap_addr[i] = 6'(i);
            cap_data[i] = 16'(mult * (i + 1));
            cap_his[i]  = 3'(i % 4);
            exp_data[i] = cap_data[i];
            exp_his[i]  = cap_his[i];
        end
    endtask

    task automatic capture(input int n, input bit done_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.pl_valid = 1'b1;
            bus.pl_addr  = cap_addr[i];
            bus.pl_data  = cap_data[i];
            bus.pl_his   = cap_his[i];
            bus.pl_done  = done_last && (i == n - 1);
        end
        @(posedge clk); #1;
        bus.pl_valid = 1'b0;
        bus.pl_done  = 1'b0;
    endtask

    task automatic drain_chk(input string tag, input int mode, input bit lat);
        int k = 0;
        int c = 0;
        int first = -1;
        while (k < 9 && c < 300) begin
            @(negedge clk);
            bus.out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (bus.out_valid) begin
                if (first < 0) first = c;
                chk({tag, "_data"}, 32'(bus.out_data), 32'(exp_data[k]));
                chk({tag, "_his"},  32'(bus.out_his),  32'(exp_his[k]));
                chk({tag, "_idx"},  32'(bus.out_idx),  32'(k));
                chk({tag, "_last"}, 32'(bus.out_last), 32'(k == 8));
                if (bus.out_ready) k++;
            end
            c++;
        end
        chk({tag, "_beats"}, 32'(k), 32'd9);
        if (mode == 0) chk({tag, "_b2b"}, 32'(c - first), 32'd9);
        if (lat) chk({tag, "_latency"}, 32'(first), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_done"},  32'(buf_done), 32'd1);
        chk({tag, "_vlow"},  32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_done1"}, 32'(buf_done), 32'd0);
        chk({tag, "_idle"},  32'(busy), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.out_data), 32'd0);
        chk({tag, "_his"},   32'(bus.out_his), 32'd0);
        chk({tag, "_idx"},   32'(bus.out_idx), 32'd0);
        chk({tag, "_last"},  32'(bus.out_last), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(buf_done), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.pl_valid  = 1'b0;
        bus.pl_addr   = 6'd0;
        bus.pl_data   = 16'd0;
        bus.pl_his    = 3'd0;
        bus.pl_done   = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();

        // Stray end-of-pass pulse in IDLE is ignored.
        @(posedge clk); #1; bus.pl_done = 1'b1;
        @(posedge clk); #1; bus.pl_done = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", 32'(busy), 32'd0);

        // Normal pass with latency check.
        fill_seq(10);
        capture(9, 1'b0);
        @(negedge clk);
        chk("lat_pre", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_drain_busy",  32'(busy), 32'd1);
        drain_chk("norm", 0, 1'b1);
        chk("norm_err", 32'(err), 32'd0);

        // Backpressure pattern 1,0,0,1,...
        capture(9, 1'b0);
        drain_chk("bp", 1, 1'b0);
        chk("bp_err", 32'(err), 32'd0);

        // Short pass closed by pl_done: stale entries 5..8 come from the previous pass.
        for (int i = 0; i < 5; i++) begin
            cap_addr[i] = 6'(i);
            cap_data[i] = 16'(100 + i);
            cap_his[i]  = 3'(3 - (i % 4));
            exp_data[i] = cap_data[i];
            exp_his[i]  = cap_his[i];
        end
        capture(5, 1'b1);
        drain_chk("short", 0, 1'b0);
        chk("short_err", 32'(err), 32'd1);

        // Out-of-range address: flagged, not written.
        do_reset();
        fill_seq(10);
        cap_addr[9] = 6'd12;
        cap_data[9] = 16'd999;
        cap_his[9]  = 3'd1;
        capture(10, 1'b0);
        @(negedge clk);
        chk("bad_addr_err", 32'(err), 32'd1);
        drain_chk("errs", 0, 1'b0);
        chk("errs_sticky0", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        chk("errs_sticky1", 32'(err), 32'd1);

        // Reset at beat 4 of a drain.
        fill_seq(7);
        capture(9, 1'b0);
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_idx == 6'd4) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_reach", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(negedge clk);
        chk("mid_nodone0", 32'(buf_done), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_nodone1", 32'(buf_done), 32'd0);
        chk("mid_idle",    32'(busy), 32'd0);

        // New full pass with a negative value at addr 3, plus overrun during drain.
        fill_seq(1);
        cap_data[3] = 16'hFFF6;
        cap_his[3]  = 3'd2;
        exp_his[3]  = 3'd2;
`ifdef POOL_OUT_RELU_EN
        exp_data[3] = 16'h0000;
`else
        exp_data[3] = 16'hFFF6;
`endif
        capture(9, 1'b0);
        repeat (2) @(negedge clk);
        chk("ovr_err_before", 32'(err), 32'd0);
        @(posedge clk); #1;
        bus.pl_valid = 1'b1;
        bus.pl_addr  = 6'd8;
        bus.pl_data  = 16'd555;
        bus.pl_his   = 3'd3;
        @(posedge clk); #1;
        bus.pl_valid = 1'b0;
        @(negedge clk);
        chk("ovr_err_after", 32'(err), 32'd1);
        drain_chk("relu", 0, 1'b0);
        chk("relu_err_sticky", 32'(err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
